// File: rtl/fetchq_pkg.sv
// fetchq_pkg: types and constants shared by the instruction fetch queue.
//   ILEN       - instruction width
//   INST_NOP   - canonical NOP (addi x0,x0,0), shown on out_inst when the queue is idle
//   FQ_PC_W    - storage width of the PC field; covers any XLEN up to 64
//   fq_entry_t - one queue entry {pc, inst}
package fetchq_pkg;

  localparam int          ILEN     = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam int          FQ_PC_W  = 64;

  typedef struct packed {
    logic [FQ_PC_W-1:0] pc;
    logic [ILEN-1:0]    inst;
  } fq_entry_t;

endpackage

// File: rtl/fetchq_ram.sv
// fetchq_ram: circular storage for the fetch queue.
// DEPTH entries of fq_entry_t, one synchronous write port, asynchronous read.
// Ports:
//   clk_i      - clock
//   wr_en_i    - write strobe
//   wr_addr_i  - write index
//   wr_data_i  - entry to store
//   rd_addr_i  - read index
//   rd_data_o  - entry at rd_addr_i (combinational)
module fetchq_ram
  import fetchq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  fq_entry_t     wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output fq_entry_t     rd_data_o
);

  fq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: sequential instruction fetch with a small decoupling queue.
// Issues one ROM read per cycle while credit remains (queued + in flight < DEPTH),
// pushes {pc, inst} one cycle later, and presents the head entry to the decoder.
// A redirect flushes the queue, drops the in-flight response and restarts at redirect_pc.
// Ports:
//   cpu_clk, cpu_rst         - clock, synchronous active-high reset
//   irom_addr / irom_data    - ROM address out, data in (1-cycle latency)
//   redirect_valid/_pc       - flush and refetch from redirect_pc
//   out_valid/_ready         - head handshake; out_pc, out_inst, out_snpc head fields
//   count                    - occupied entries
// Build option: FETCHQ_BYPASS_EN lets a response arriving into an empty queue appear
// on out_* in the same cycle, and skips the write if it is consumed immediately.
module ifu_fetch_queue
  import fetchq_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rst,
  output logic [XLEN-1:0]        irom_addr,
  input  logic [31:0]            irom_data,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [31:0]            out_inst,
  output logic [XLEN-1:0]        out_snpc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] tag_pc_q, tag_pc_d;
  logic            inflight_q, inflight_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic      credit_ok, issue, push, wr_en, pop_ram, bypass_hit;
  fq_entry_t wr_entry, rd_entry;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_inst;

  // Credit counts the in-flight read, so the response always has a free slot.
  always_comb begin
    credit_ok = ({1'b0, count_q} + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH);
    issue     = !cpu_rst && !redirect_valid && credit_ok;
    push      = !cpu_rst && !redirect_valid && inflight_q;
`ifdef FETCHQ_BYPASS_EN
    bypass_hit = (count_q == '0) && inflight_q;
`else
    bypass_hit = 1'b0;
`endif
    // Uses only registered state, so out_valid never follows redirect_valid.
    out_valid = !cpu_rst && ((count_q != '0) || bypass_hit);
    pop_ram   = !cpu_rst && out_ready && (count_q != '0);
    // A bypassed entry taken in its arrival cycle never occupies storage.
    wr_en     = push && !(bypass_hit && out_ready);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_pc_d   = tag_pc_q;
    inflight_d = issue;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        tag_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (wr_en)   tail_d = tail_q + PW'(1);
      if (pop_ram) head_d = head_q + PW'(1);
      count_d = count_q + CW'(wr_en) - CW'(pop_ram);
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      fetch_pc_q <= RESET_PC;
      tag_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_pc_q   <= tag_pc_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    wr_entry.pc   = FQ_PC_W'(tag_pc_q);
    wr_entry.inst = irom_data;
  end

  fetchq_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i     (cpu_clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (tail_q),
    .wr_data_i (wr_entry),
    .rd_addr_i (head_q),
    .rd_data_o (rd_entry)
  );

  always_comb begin
    head_pc   = XLEN'(rd_entry.pc);
    head_inst = rd_entry.inst;
`ifdef FETCHQ_BYPASS_EN
    if (count_q == '0) begin
      head_pc   = tag_pc_q;
      head_inst = irom_data;
    end
`endif
  end

  assign irom_addr = fetch_pc_q;
  assign out_pc    = head_pc;
  assign out_inst  = out_valid ? head_inst : INST_NOP;
  assign out_snpc  = head_pc + XLEN'(4);
  assign count     = count_q;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
module tb_ifu_fetch_queue;

`ifdef FETCHQ_BYPASS_EN
  localparam int          LAT    = 1;
  localparam logic [31:0] SS_CNT = 32'd0;
  localparam logic [31:0] BYP    = 32'd1;
`else
  localparam int          LAT    = 2;
  localparam logic [31:0] SS_CNT = 32'd1;
  localparam logic [31:0] BYP    = 32'd0;
`endif

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: DEPTH=4
  logic        rst_a, redir_v, out_ready_a, out_valid_a, irom_data_valid_dummy;
  logic [31:0] redir_pc, irom_addr_a, irom_data_a, out_pc_a, out_inst_a, out_snpc_a;
  logic [2:0]  count_a;

  // DUT B: DEPTH=8
  logic        rst_b, redir_v_b, out_ready_b, out_valid_b;
  logic [31:0] redir_pc_b, irom_addr_b, irom_data_b, out_pc_b, out_inst_b, out_snpc_b;
  logic [3:0]  count_b;

  ifu_fetch_queue u_dut_a (
    .cpu_clk(clk), .cpu_rst(rst_a), .irom_addr(irom_addr_a), .irom_data(irom_data_a),
    .redirect_valid(redir_v), .redirect_pc(redir_pc),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_pc(out_pc_a),
    .out_inst(out_inst_a), .out_snpc(out_snpc_a), .count(count_a)
  );

  ifu_fetch_queue #(.DEPTH(8)) u_dut_b (
    .cpu_clk(clk), .cpu_rst(rst_b), .irom_addr(irom_addr_b), .irom_data(irom_data_b),
    .redirect_valid(redir_v_b), .redirect_pc(redir_pc_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_pc(out_pc_b),
    .out_inst(out_inst_b), .out_snpc(out_snpc_b), .count(count_b)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  always @(posedge clk) begin
    irom_data_a <= rom(irom_addr_a);
    irom_data_b <= rom(irom_addr_b);
  end

  int vecs = 0;
  int errs = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("no_overflow_a", 32'(count_a <= 3'd4), 32'd1);
      chk("no_overflow_b", 32'(count_b <= 4'd8), 32'd1);
    end
  end

  initial begin
    logic [31:0] exp_pc;
    int pops;
    irom_data_valid_dummy = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    redir_v = 1'b0; redir_pc = '0;
    redir_v_b = 1'b0; redir_pc_b = '0;
    out_ready_a = 1'b1; out_ready_b = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid_a), 32'd0);
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_addr", irom_addr_a, RST_PC);
    mon_en = 1'b1;

    // Release with out_ready=1: PCs 0,4,8 starting at cycle LAT
    rst_a = 1'b0;
    chk("c0_valid", 32'(out_valid_a), 32'd0);
    for (int c = 1; c <= LAT + 2; c++) begin
      tick();
      if (c < LAT) begin
        chk("rel_valid_early", 32'(out_valid_a), 32'd0);
      end else begin
        chk("rel_valid", 32'(out_valid_a), 32'd1);
        chk("rel_pc", out_pc_a, RST_PC + 32'(4 * (c - LAT)));
        chk("rel_inst", out_inst_a, rom(RST_PC + 32'(4 * (c - LAT))));
        chk("rel_snpc", out_snpc_a, RST_PC + 32'(4 * (c - LAT)) + 32'd4);
        chk("rel_count", 32'(count_a), SS_CNT);
      end
    end

    // Stall: count saturates at 4, fetch address frozen
    rst_a = 1'b1; out_ready_a = 1'b0;
    tick();
    rst_a = 1'b0;
    repeat (10) tick();
    chk("sat_count", 32'(count_a), 32'd4);
    chk("sat_addr", irom_addr_a, 32'h8000_0010);
    chk("sat_head", out_pc_a, RST_PC);
    repeat (3) tick();
    chk("sat_count2", 32'(count_a), 32'd4);
    chk("sat_addr2", irom_addr_a, 32'h8000_0010);

    // Redirect with count=3 and a read in flight
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    repeat (4) tick();
    chk("pre_redir_count", 32'(count_a), 32'd3);
    redir_v = 1'b1; redir_pc = 32'h8000_0100;
    tick();
    redir_v = 1'b0;
    chk("redir_count", 32'(count_a), 32'd0);
    chk("redir_valid", 32'(out_valid_a), 32'd0);
    chk("redir_addr", irom_addr_a, 32'h8000_0100);
    tick();
    chk("redir_p2_valid", 32'(out_valid_a), BYP);
    tick();
    chk("redir_p3_valid", 32'(out_valid_a), 32'd1);
    chk("redir_p3_pc", out_pc_a, 32'h8000_0100);
    chk("redir_p3_count", 32'(count_a), 32'd1);

    // One-cycle reset with count=2
    tick();
    chk("mid_count", 32'(count_a), 32'd2);
    rst_a = 1'b1;
    tick();
    chk("mrst_count", 32'(count_a), 32'd0);
    chk("mrst_valid", 32'(out_valid_a), 32'd0);
    chk("mrst_addr", irom_addr_a, RST_PC);
    rst_a = 1'b0;
    repeat (LAT) tick();
    chk("mrst_refetch_valid", 32'(out_valid_a), 32'd1);
    chk("mrst_refetch_pc", out_pc_a, RST_PC);

    // Redirect to top of address space: out_snpc wraps to 0
    redir_v = 1'b1; redir_pc = 32'hFFFF_FFFC;
    tick();
    redir_v = 1'b0;
    repeat (2) tick();
    chk("wrap_valid", 32'(out_valid_a), 32'd1);
    chk("wrap_pc", out_pc_a, 32'hFFFF_FFFC);
    chk("wrap_snpc", out_snpc_a, 32'h0000_0000);

    // DEPTH=8 streaming with random backpressure
    rst_b = 1'b0;
    exp_pc = RST_PC;
    pops = 0;
    for (int i = 0; i < 1000; i++) begin
      out_ready_b = 1'($urandom_range(0, 1));
      if (out_valid_b && out_ready_b) begin
        chk("strm_pc", out_pc_b, exp_pc);
        chk("strm_inst", out_inst_b, rom(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      tick();
    end
    chk("strm_progress", 32'(pops > 300), 32'd1);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
